// File: rtl/seg_op_encoder.sv
// seg_op_encoder: recovers a 3-bit ALU opcode {A,B,C} from an asynchronous 7-segment pattern.
// The input is synchronized and then filtered for stability. Table patterns produce a held
// opcode with a valid/ack handshake. Other non-blank stable patterns produce an error pulse.
// Optional feature: define SEG_ERR_CNT_EN to add a saturating 8-bit invalid-pattern counter.
// When it is undefined, err_cnt is tied to zero.
module seg_op_encoder #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       op_valid,
  input  logic       op_ack,
  output logic       op_err,
  output logic       op_ovr,
  output logic [7:0] err_cnt
);

  localparam int unsigned     CntW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [6:0]      Blank  = 7'b0000000;

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  state_e                       state_q, state_d;
  logic [SYNC_STAGES-1:0][6:0]  sync_q;
  logic [6:0]                   sample;
  logic [6:0]                   prev_q;
  logic [6:0]                   last_acc_q, last_acc_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic                         decode;
  logic                         pat_ok;
  logic [2:0]                   pat_op;
  logic [2:0]                   abc_q, abc_d;
  logic                         op_valid_q, op_valid_d;
  logic                         op_err_q, op_err_d;
  logic                         op_ovr_q, op_ovr_d;

  // Input synchronizer chain; the oldest stage feeds the filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], seg_in};
    end
  end

  assign sample = sync_q[SYNC_STAGES-1];

  // State register: FSM, stability counter, previous sample and last accepted pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      prev_q     <= '0;
      last_acc_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_q     <= sample;
      last_acc_q <= last_acc_d;
    end
  end

  // Pattern table lookup on the pattern that has been stable (prev_q).
  always_comb begin
    pat_ok = 1'b1;
    pat_op = 3'd0;
    case (prev_q)
      7'b1111111: pat_op = 3'd0;
      7'b0001000: pat_op = 3'd1;
      7'b0100100: pat_op = 3'd2;
      7'b1000010: pat_op = 3'd3;
      7'b0001001: pat_op = 3'd4;
      7'b0000001: pat_op = 3'd5;
      7'b0110000: pat_op = 3'd6;
      7'b1001000: pat_op = 3'd7;
      default:    pat_ok = 1'b0;
    endcase
  end

  // Next-state logic for the stability filter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_acc_d = last_acc_q;
    decode     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sample != Blank) begin
          state_d = StSettle;
          cnt_d   = CntOne;
        end
      end
      StSettle: begin
        if (cnt_q == CntMax) begin
          // STABLE_CYCLES identical samples seen; prev_q holds that pattern.
          decode     = 1'b1;
          last_acc_d = prev_q;
          state_d    = StHold;
          cnt_d      = '0;
        end else if (sample == Blank) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (sample == prev_q) begin
          cnt_d = cnt_q + 1'b1;  // below CntMax here, so it cannot wrap
        end else begin
          cnt_d = CntOne;
        end
      end
      StHold: begin
        if (sample == Blank) begin
          state_d    = StIdle;
          last_acc_d = '0;
        end else if (sample != last_acc_q) begin
          state_d = StSettle;
          cnt_d   = CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output next-values: handshake, opcode load, error and overwrite pulses.
  always_comb begin
    abc_d      = abc_q;
    op_valid_d = op_valid_q;
    op_err_d   = 1'b0;
    op_ovr_d   = 1'b0;
    if (op_valid_q && op_ack) begin
      op_valid_d = 1'b0;
    end
    if (decode) begin
      if (pat_ok) begin
        abc_d      = pat_op;
        op_valid_d = 1'b1;
        op_ovr_d   = op_valid_q & ~op_ack;
      end else begin
        op_err_d = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abc_q      <= '0;
      op_valid_q <= 1'b0;
      op_err_q   <= 1'b0;
      op_ovr_q   <= 1'b0;
    end else begin
      abc_q      <= abc_d;
      op_valid_q <= op_valid_d;
      op_err_q   <= op_err_d;
      op_ovr_q   <= op_ovr_d;
    end
  end

  assign A        = abc_q[2];
  assign B        = abc_q[1];
  assign C        = abc_q[0];
  assign op_valid = op_valid_q;
  assign op_err   = op_err_q;
  assign op_ovr   = op_ovr_q;

`ifdef SEG_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating invalid-pattern counter, advanced together with the op_err pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (op_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_seg_op_encoder.sv
// Scoreboard bench for seg_op_encoder (SYNC_STAGES=2, STABLE_CYCLES=4).
// Stimulus pushes expected output events (kind, opcode, cycle). A negedge monitor
// pops them whenever the DUT presents a new opcode, an error pulse or an overwrite pulse.
module tb_seg_op_encoder;

  localparam int LAT     = 6;  // SYNC_STAGES + STABLE_CYCLES
  localparam int EvValid = 0;
  localparam int EvErr   = 1;
  localparam int EvOvr   = 2;

  typedef struct {
    int         kind;
    logic [2:0] abc;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [6:0] seg_in = 7'b0;
  logic       op_ack = 1'b0;
  logic       A, B, C, op_valid, op_err, op_ovr;
  logic [7:0] err_cnt;

  int   cyc         = 0;
  int   checks      = 0;
  int   errors      = 0;
  int   exp_err_cnt = 0;
  int   t0          = 0;
  logic ack_at_edge = 1'b0;
  logic valid_prev  = 1'b0;

  seg_op_encoder #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg_in  (seg_in),
    .A       (A),
    .B       (B),
    .C       (C),
    .op_valid(op_valid),
    .op_ack  (op_ack),
    .op_err  (op_err),
    .op_ovr  (op_ovr),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ack_at_edge <= op_ack;
    cyc         <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic see_event(input int kind, input logic [2:0] abc);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d abc %b at cycle %0d, required no event",
               kind, abc, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.abc !== abc || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind %0d abc %b cycle %0d, required kind %0d abc %b cycle %0d",
                 kind, abc, cyc, e.kind, e.abc, e.cyc);
      end
    end
  endtask

  // Monitor: a new opcode is presented when op_valid rises or is re-asserted right after an ack.
  always @(negedge clk) begin
    if (op_err) see_event(EvErr, {A, B, C});
    if (op_valid && (!valid_prev || ack_at_edge)) see_event(EvValid, {A, B, C});
    if (op_ovr) see_event(EvOvr, {A, B, C});
    valid_prev = op_valid;
  end

  task automatic expect_ev(input int kind, input logic [2:0] abc, input int at);
    ev_t e;
    e.kind = kind;
    e.abc  = abc;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [6:0] p);
    @(negedge clk);
    seg_in = p;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_now();
    op_ack = 1'b1;
    @(negedge clk);
    op_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_abc"}, {29'd0, A, B, C}, 32'd0);
    check({tag, "_valid"}, {31'd0, op_valid}, 32'd0);
    check({tag, "_err"}, {31'd0, op_err}, 32'd0);
    check({tag, "_ovr"}, {31'd0, op_ovr}, 32'd0);
    check({tag, "_errcnt"}, {24'd0, err_cnt}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SEG_ERR_CNT_EN
    exp_err_cnt = 1;
`else
    exp_err_cnt = 0;
`endif
    // Reset state.
    rst_n = 1'b0;
    wait_cyc(3);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Valid pattern 1000010 -> 011, held until ack.
    drive(7'b1000010);
    t0 = cyc;
    expect_ev(EvValid, 3'b011, t0 + 1 + LAT);
    wait_cyc(9);
    check("t1_hold_valid", {31'd0, op_valid}, 32'd1);
    check("t1_hold_abc", {29'd0, A, B, C}, 32'd3);
    ack_now();
    check("t1_acked_valid", {31'd0, op_valid}, 32'd0);

    // Short-lived pattern then blank: nothing decoded.
    drive(7'b0110000);
    wait_cyc(2);
    drive(7'b0000000);
    wait_cyc(10);
    check("t2_valid", {31'd0, op_valid}, 32'd0);
    check("t2_abc", {29'd0, A, B, C}, 32'd3);
    check("t2_err", {31'd0, op_err}, 32'd0);

    // Invalid stable pattern: one error pulse, opcode untouched.
    drive(7'b1010101);
    t0 = cyc;
    expect_ev(EvErr, 3'b011, t0 + 1 + LAT);
    wait_cyc(7);
    drive(7'b0000000);
    check("t3_abc", {29'd0, A, B, C}, 32'd3);
    check("t3_valid", {31'd0, op_valid}, 32'd0);
    check("t3_errcnt", {24'd0, err_cnt}, exp_err_cnt);
    wait_cyc(8);

    // 1111111 accepted and acked, blank 5 cycles, accepted again.
    drive(7'b1111111);
    t0 = cyc;
    expect_ev(EvValid, 3'b000, t0 + 1 + LAT);
    wait_cyc(7);
    ack_now();
    drive(7'b0000000);
    wait_cyc(4);
    drive(7'b1111111);
    t0 = cyc;
    expect_ev(EvValid, 3'b000, t0 + 1 + LAT);
    wait_cyc(7);
    ack_now();
    check("t5_abc", {29'd0, A, B, C}, 32'd0);

    // Overwrite of an unacknowledged opcode.
    drive(7'b0001001);
    t0 = cyc;
    expect_ev(EvValid, 3'b100, t0 + 1 + LAT);
    wait_cyc(8);
    drive(7'b1001000);
    t0 = cyc;
    expect_ev(EvOvr, 3'b111, t0 + 1 + LAT);
    wait_cyc(8);
    check("t4_ovr_valid", {31'd0, op_valid}, 32'd1);
    check("t4_ovr_abc", {29'd0, A, B, C}, 32'd7);

    // Decode coinciding with ack: new opcode, valid stays, no overwrite pulse.
    drive(7'b0001001);
    t0 = cyc;
    expect_ev(EvValid, 3'b100, t0 + 1 + LAT);
    wait_cyc(6);
    ack_now();
    check("t4_ackdec_valid", {31'd0, op_valid}, 32'd1);
    check("t4_ackdec_abc", {29'd0, A, B, C}, 32'd4);
    check("t4_ackdec_ovr", {31'd0, op_ovr}, 32'd0);

    // Reset mid-SETTLE (cnt=3), opcode 100 still pending.
    drive(7'b1000010);
    wait_cyc(5);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    expect_ev(EvValid, 3'b011, t0 + 1 + LAT);
    wait_cyc(7);
    check("t6_valid", {31'd0, op_valid}, 32'd1);
    wait_cyc(2);
    ack_now();
    wait_cyc(3);

    // Every expected event must have been observed.
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d outstanding, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
